// File: rtl/poly_dds_pkg.sv
// Shared definitions for the poly_dds synthesizer: command opcodes, the
// command FSM state type and the per-opcode payload length.
package poly_dds_pkg;

  localparam logic [2:0] OP_FREQ = 3'd1;
  localparam logic [2:0] OP_ENV  = 3'd2;
  localparam logic [2:0] OP_WAVE = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_APPLY   = 2'd2
  } cmd_state_t;

  // Zero marks an opcode that the decoder rejects.
  function automatic logic [1:0] payload_len(input logic [2:0] op);
    case (op)
      OP_FREQ:         return 2'd2;
      OP_ENV, OP_WAVE: return 2'd1;
      default:         return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/poly_dds_cmd_fsm.sv
// Byte-serial command decoder with payload holding register.
// Optional payload timeout is enabled by defining POLY_DDS_CMD_TIMEOUT_EN.
//
// state      | meaning
// ST_IDLE    | waiting for a command byte
// ST_PAYLOAD | collecting payload bytes, remain = bytes still expected
// ST_APPLY   | one cycle, wr_en high, target register updates at its end
module poly_dds_cmd_fsm
  import poly_dds_pkg::*;
#(
  parameter int VOICES      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       cmd_valid,
  input  logic [7:0]                 cmd_data,
  output logic                       wr_en,
  output logic [$clog2(VOICES)-1:0]  wr_voice,
  output logic [2:0]                 wr_op,
  output logic [15:0]                wr_value,
  output logic                       cmd_err,
  output logic [7:0]                 last_cmd
);

  localparam int IDX_W = $clog2(VOICES);

  cmd_state_t  state;
  logic [7:0]  cmd_r;
  logic [1:0]  remain;
  logic        bad;
  logic [15:0] hold;
  logic [1:0]  len;
  logic        bad_voice;

`ifdef POLY_DDS_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  assign len       = payload_len(cmd_data[7:5]);
  assign bad_voice = {1'b0, cmd_data[4:0]} >= 6'(VOICES);
  assign wr_voice  = cmd_r[IDX_W-1:0];
  assign wr_op     = cmd_r[7:5];
  assign wr_value  = hold;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      cmd_r    <= '0;
      remain   <= '0;
      bad      <= 1'b0;
      hold     <= '0;
      wr_en    <= 1'b0;
      cmd_err  <= 1'b0;
      last_cmd <= '0;
`ifdef POLY_DDS_CMD_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      wr_en   <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        ST_PAYLOAD: begin
          if (cmd_valid) begin
            hold   <= {hold[7:0], cmd_data};
            remain <= remain - 2'd1;
`ifdef POLY_DDS_CMD_TIMEOUT_EN
            to_cnt <= TO_W'(TIMEOUT_CYC - 1);
`endif
            if (remain == 2'd1) begin
              state <= bad ? ST_IDLE : ST_APPLY;
              wr_en <= !bad;
            end
          end
`ifdef POLY_DDS_CMD_TIMEOUT_EN
          else if (to_cnt == '0) begin
            state   <= ST_IDLE;
            cmd_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
`endif
        end
        ST_APPLY: begin
          state    <= ST_IDLE;
          last_cmd <= cmd_r;
        end
        default: ;
      endcase
      // A byte landing in APPLY starts the next frame in the same cycle.
      if (cmd_valid && state != ST_PAYLOAD) begin
        if (len == 2'd0) begin
          cmd_err <= 1'b1;
        end else begin
          cmd_r   <= cmd_data;
          remain  <= len;
          bad     <= bad_voice;
          cmd_err <= bad_voice;
          state   <= ST_PAYLOAD;
`ifdef POLY_DDS_CMD_TIMEOUT_EN
          to_cnt  <= TO_W'(TIMEOUT_CYC - 1);
`endif
        end
      end
    end
  end

endmodule

// File: rtl/poly_dds.sv
// Multi-voice DDS: register file, sample divider, voice scan over a shared ROM
// and mixer. Define POLY_DDS_CMD_TIMEOUT_EN to enable the command payload timeout.
module poly_dds
  import poly_dds_pkg::*;
#(
  parameter int VOICES      = 8,
  parameter int PHASE_W     = 32,
  parameter int FREQ_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int WSEL_W      = 3,
  parameter int SAMPLE_W    = 8,
  parameter int ENV_W       = 8,
  parameter int DAC_W       = 8,
  parameter int DIV         = 500,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     cmd_valid,
  input  logic [7:0]               cmd_data,
  output logic [WSEL_W+ADDR_W-1:0] rom_addr,
  input  logic [SAMPLE_W-1:0]      rom_q,
  output logic [DAC_W-1:0]         dac_out,
  output logic                     sample_strobe,
  output logic                     cmd_err,
  output logic [7:0]               last_cmd
);

  localparam int IDX_W  = $clog2(VOICES);
  localparam int DIV_W  = $clog2(DIV);
  localparam int PROD_W = SAMPLE_W + ENV_W;
  localparam int ACC_W  = PROD_W + IDX_W;

  logic [FREQ_W-1:0]  freq  [VOICES];
  logic [ENV_W-1:0]   env   [VOICES];
  logic [WSEL_W-1:0]  wave  [VOICES];
  logic [PHASE_W-1:0] phase [VOICES];

  logic              wr_en;
  logic [IDX_W-1:0]  wr_voice;
  logic [2:0]        wr_op;
  logic [15:0]       wr_value;

  poly_dds_cmd_fsm #(
    .VOICES      (VOICES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_cmd (
    .clk       (clk),
    .nreset    (nreset),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .wr_en     (wr_en),
    .wr_voice  (wr_voice),
    .wr_op     (wr_op),
    .wr_value  (wr_value),
    .cmd_err   (cmd_err),
    .last_cmd  (last_cmd)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < VOICES; i++) begin
        freq[i] <= '0;
        env[i]  <= '0;
        wave[i] <= '0;
      end
    end else if (wr_en) begin
      case (wr_op)
        OP_FREQ: freq[wr_voice] <= wr_value[FREQ_W-1:0];
        OP_ENV:  env[wr_voice]  <= wr_value[7 -: ENV_W];
        OP_WAVE: wave[wr_voice] <= wr_value[WSEL_W-1:0];
        default: ;
      endcase
    end
  end

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic              scan_on;
  logic [IDX_W-1:0]  scan_idx;
  logic              issue;
  logic [IDX_W-1:0]  issue_idx;
  logic              v1, v2, last1, last2;
  logic [ENV_W-1:0]  env_p1, env_p2;
  logic [ACC_W-1:0]  acc;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc_next;

  assign tick      = (div_cnt == DIV_W'(DIV - 1));
  assign issue     = tick | scan_on;
  assign issue_idx = tick ? '0 : scan_idx;
  assign prod      = rom_q * env_p2;
  assign acc_next  = acc + ACC_W'(prod);

  // Voice k is issued at t0+k so its address is on rom_addr at t0+1+k and its
  // sample reaches the mixer at t0+2+k; env rides a matching two-stage pipe.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_cnt       <= '0;
      scan_on       <= 1'b0;
      scan_idx      <= '0;
      rom_addr      <= '0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      last1         <= 1'b0;
      last2         <= 1'b0;
      env_p1        <= '0;
      env_p2        <= '0;
      acc           <= '0;
      dac_out       <= '0;
      sample_strobe <= 1'b0;
      for (int i = 0; i < VOICES; i++) phase[i] <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;

      if (tick) begin
        scan_on  <= 1'b1;
        scan_idx <= IDX_W'(1);
      end else if (scan_on) begin
        if (scan_idx == IDX_W'(VOICES - 1)) scan_on <= 1'b0;
        scan_idx <= scan_idx + 1'b1;
      end

      if (issue) begin
        rom_addr         <= {wave[issue_idx], phase[issue_idx][PHASE_W-1 -: ADDR_W]};
        phase[issue_idx] <= phase[issue_idx] + PHASE_W'(freq[issue_idx]);
        env_p1           <= env[issue_idx];
      end
      v1    <= issue;
      last1 <= issue && (issue_idx == IDX_W'(VOICES - 1));

      v2     <= v1;
      last2  <= last1;
      env_p2 <= env_p1;

      sample_strobe <= 1'b0;
      if (v2) begin
        if (last2) begin
          dac_out       <= acc_next[ACC_W-1 -: DAC_W];
          sample_strobe <= 1'b1;
          acc           <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule

// File: doc/poly_dds.md
# poly_dds

Multi-voice direct digital synthesis core, the next generation of the single-voice wavetable oscillator. It holds VOICES independent phase accumulators with per-voice frequency, waveform and envelope registers, written through a byte-serial command stream. One shared wavetable ROM is time-multiplexed across voices. The mixed result drives the R2R DAC output.

## Interface
- VOICES, 8: voice count, 2..32
- PHASE_W, 32: phase accumulator width
- FREQ_W, 16: frequency word width; FREQ_W ≤ PHASE_W, FREQ_W ≤ 16
- ADDR_W, 12: per-table ROM address width
- WSEL_W, 3: waveform select width
- SAMPLE_W, 8: ROM sample width, unsigned offset-binary
- ENV_W, 8: envelope width
- DAC_W, 8: output width
- DIV, 500: clk cycles per sample tick; DIV ≥ VOICES+4
- TIMEOUT_CYC, 4096: partial-frame abort time; used only with the timeout feature
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- cmd_valid  in  1  one-cycle strobe, cmd_data holds one byte
- cmd_data  in  8  command or payload byte
- rom_addr  out  WSEL_W+ADDR_W  {wave, phase top bits}
- rom_q  in  SAMPLE_W  ROM data, exactly 1 cycle after rom_addr
- dac_out  out  DAC_W  mixed sample to R2R
- sample_strobe  out  1  one-cycle pulse when dac_out updates
- cmd_err  out  1  one-cycle pulse on a rejected or aborted frame
- last_cmd  out  8  last accepted command byte, for LED display

## Operation
- Reset: all phase, freq, env and wave registers are 0. Divider is 0. dac_out, sample_strobe, cmd_err, last_cmd and rom_addr are 0. Command FSM is in IDLE.
- Command byte: [7:5] is the opcode and [4:0] is the voice index.
  - Opcode 1, FREQ: 2 payload bytes, MSB first. The low FREQ_W bits are kept.
  - Opcode 2, ENV: 1 payload byte. The top ENV_W bits are kept.
  - Opcode 3, WAVE: 1 payload byte. The low WSEL_W bits are kept.
- Command FSM states: IDLE → PAYLOAD (remaining-byte counter) → APPLY (1 cycle) → IDLE.
- Rejection: any other opcode, or a voice index ≥ VOICES, pulses cmd_err.
  - Unknown opcode: the FSM stays in IDLE.
  - Bad voice with a valid opcode: the FSM still consumes the payload length, then discards it.
- Atomic writes: the FREQ value is assembled in a holding register. The target register updates only in APPLY, so no half-written frequency is ever used.
- last_cmd updates in APPLY.
- Sequencer: the divider counts 0..DIV-1. Its wrap is the tick, at cycle t0. At t0+1+k, for k = 0..VOICES-1:
  - rom_addr = {wave[k], phase[k][PHASE_W-1 -: ADDR_W]};
  - phase[k] += zero-extended freq[k], modulo 2^PHASE_W;
  - env[k] is piped alongside the address.
- At t0+2+k the accumulator adds rom_q × env_pipe.
- The accumulator is SAMPLE_W+ENV_W+clog2(VOICES) bits wide and cannot overflow.
- dac_out = accumulator >> (SAMPLE_W+ENV_W+clog2(VOICES)−DAC_W).
- Write/scan collision: an APPLY in the same cycle that voice k is addressed. The scan uses the old value; the new value is used from the next tick.
- Voice count: no mode flag. Voices with env = 0 contribute 0.

## Timing
- dac_out and sample_strobe are registered at t0+VOICES+2. The output holds until the next tick.
- Command-to-effect: APPLY occurs 1 cycle after the final byte's cmd_valid. The new value is first used at the next tick.
- Byte spacing is arbitrary. A cmd_valid arriving during APPLY is a command byte for the next frame and is taken in IDLE in the same cycle.
- nreset asserted mid-frame or mid-scan clears everything immediately. No partial output is produced.

## Configuration
- POLY_DDS_CMD_TIMEOUT_EN defined: in PAYLOAD, a counter restarts on each cmd_valid. If it reaches TIMEOUT_CYC, the frame is dropped, cmd_err pulses and the FSM returns to IDLE.
- Not defined: PAYLOAD waits indefinitely. TIMEOUT_CYC is unused.

## Structure
- Package poly_dds_pkg holds:
  - opcode constants OP_FREQ = 3'd1, OP_ENV = 3'd2, OP_WAVE = 3'd3;
  - the FSM state enum;
  - the payload-length function.
- Sub-module poly_dds_cmd_fsm holds the byte decoder, timeout and holding register. It emits a write strobe, voice, field select and value. The top holds the register file, divider, scan sequencer and mixer.

## Test plan
- Reset, then run 3 ticks with a ROM model returning 0xFF: dac_out = 0, cmd_err never pulses, sample_strobe every DIV cycles.
- Parameters PHASE_W=16, ADDR_W=8. Bytes 0x20,0x01,0x00 (FREQ voice 0 = 0x0100) and 0x40,0xFF (ENV voice 0): rom_addr low byte for voice 0 steps 0,1,2… on successive ticks.
- VOICES=2, all widths 8, ROM returns 0xFF, ENV = 0xFF on both voices: dac_out = 254 (130050 >> 9) at t0+4.
- VOICES=8, byte 0x3F then 0x12,0x34: cmd_err pulses, no register changes, next byte 0x41 is decoded as a command.
- With POLY_DDS_CMD_TIMEOUT_EN and TIMEOUT_CYC=16: byte 0x21 then 16 idle cycles gives a cmd_err pulse and voice 1 freq unchanged. Without the macro, a later 0x00,0x05 completes the write with freq = 5.
- Assert nreset between the two FREQ payload bytes: after release all freq = 0, and the trailing byte is decoded as a command.
